// File: rtl/cix32_mem_arbiter.sv
// Round-robin arbiter merging the CIX-32 fetch and data ports onto one 32-bit
// memory bus, with one outstanding transaction and a watchdog that aborts dead slaves.
module cix32_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    input  logic        imem_req,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    input  logic        dmem_we,
    input  logic        dmem_req,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_we,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        timeout_irq,
    output logic [31:0] timeout_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            last_grant_dmem;
    logic            grant_dmem;
    logic [TO_W-1:0] wd_count;

    logic            pick_dmem;
    logic            wd_expired;
    logic [31:0]     resp_data;

    // On a tie, serve the master that did not win last time.
    assign pick_dmem  = dmem_req && (!imem_req || !last_grant_dmem);
    assign wd_expired = (wd_count == TO_W'(TIMEOUT_CYCLES - 1));
    assign resp_data  = bus_ready ? bus_rdata : 32'hFFFF_FFFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant_dmem <= 1'b0;
            grant_dmem      <= 1'b0;
            wd_count        <= '0;
            imem_rdata      <= '0;
            imem_ready      <= 1'b0;
            dmem_rdata      <= '0;
            dmem_ready      <= 1'b0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
            bus_wstrb       <= '0;
            bus_we          <= 1'b0;
            bus_valid       <= 1'b0;
            timeout_irq     <= 1'b0;
            timeout_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req || dmem_req) begin
                        grant_dmem      <= pick_dmem;
                        last_grant_dmem <= pick_dmem;
                        bus_addr        <= pick_dmem ? dmem_addr : imem_addr;
                        bus_we          <= pick_dmem && dmem_we;
                        bus_wdata       <= (pick_dmem && dmem_we) ? dmem_wdata : 32'h0;
                        bus_wstrb       <= (pick_dmem && dmem_we) ? dmem_wstrb : 4'h0;
                        bus_valid       <= 1'b1;
                        wd_count        <= '0;
                        state           <= BUS;
                    end
                end
                BUS: begin
                    // A ready in the final watchdog cycle still counts as a normal completion.
                    if (bus_ready || wd_expired) begin
                        bus_valid   <= 1'b0;
                        timeout_irq <= !bus_ready;
                        if (!bus_ready) begin
                            timeout_addr <= bus_addr;
                        end
                        if (grant_dmem) begin
                            dmem_ready <= 1'b1;
                            dmem_rdata <= bus_we ? 32'h0 : resp_data;
                        end else begin
                            imem_ready <= 1'b1;
                            imem_rdata <= resp_data;
                        end
                        state <= RESP;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                RESP: begin
                    imem_ready  <= 1'b0;
                    dmem_ready  <= 1'b0;
                    timeout_irq <= 1'b0;
                    wd_count    <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    bus_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cix32_mem_arbiter.sv
// Directed bench for cix32_mem_arbiter: a per-cycle vector table for fetch and
// stalled store, plus hand sequences for timeout, its boundary, reset and contention.
module tb_cix32_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_we;
    logic        dmem_req;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_we;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        timeout_irq;
    logic [31:0] timeout_addr;

    int total = 0;
    int bad   = 0;

    cix32_mem_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_we      (dmem_we),
        .dmem_req     (dmem_req),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_we       (bus_we),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .timeout_irq  (timeout_irq),
        .timeout_addr (timeout_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwstrb;
        logic        brdy;
        logic [31:0] brdata;
        logic        e_valid;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_iready;
        logic [31:0] e_irdata;
        logic        e_dready;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwe, input logic [31:0] daddr,
        input logic [31:0] dwdata, input logic [3:0] dwstrb,
        input logic brdy, input logic [31:0] brdata,
        input logic e_valid, input logic [31:0] e_addr, input logic e_we,
        input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
        input logic e_iready, input logic [31:0] e_irdata,
        input logic e_dready, input logic [31:0] e_drdata);
        vec_t v;
        v.ireq = ireq;       v.iaddr = iaddr;
        v.dreq = dreq;       v.dwe = dwe;        v.daddr = daddr;
        v.dwdata = dwdata;   v.dwstrb = dwstrb;
        v.brdy = brdy;       v.brdata = brdata;
        v.e_valid = e_valid; v.e_addr = e_addr;  v.e_we = e_we;
        v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
        v.e_iready = e_iready; v.e_irdata = e_irdata;
        v.e_dready = e_dready; v.e_drdata = e_drdata;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        imem_req   = v.ireq;
        imem_addr  = v.iaddr;
        dmem_req   = v.dreq;
        dmem_we    = v.dwe;
        dmem_addr  = v.daddr;
        dmem_wdata = v.dwdata;
        dmem_wstrb = v.dwstrb;
        bus_ready  = v.brdy;
        bus_rdata  = v.brdata;
    endtask

    task automatic clear_inputs();
        imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_we = 0;
        dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0; bus_ready = 0; bus_rdata = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " bus_valid"},    32'(bus_valid), 0);
        check_output({tag, " bus_addr"},     bus_addr, 0);
        check_output({tag, " bus_we"},       32'(bus_we), 0);
        check_output({tag, " bus_wstrb"},    32'(bus_wstrb), 0);
        check_output({tag, " bus_wdata"},    bus_wdata, 0);
        check_output({tag, " imem_ready"},   32'(imem_ready), 0);
        check_output({tag, " imem_rdata"},   imem_rdata, 0);
        check_output({tag, " dmem_ready"},   32'(dmem_ready), 0);
        check_output({tag, " dmem_rdata"},   dmem_rdata, 0);
        check_output({tag, " timeout_irq"},  32'(timeout_irq), 0);
        check_output({tag, " timeout_addr"}, timeout_addr, 0);
    endtask

    // Issue one DMEM load and wait for its ready; ready_at>0 raises bus_ready in that valid cycle.
    task automatic run_dmem_load(input logic [31:0] addr, input int ready_at,
                                 input logic [31:0] rdata, output int vcount, output bit got);
        vcount = 0;
        got    = 0;
        dmem_req = 1; dmem_we = 0; dmem_addr = addr; bus_ready = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (dmem_ready) begin
                got = 1;
            end else if (bus_valid) begin
                vcount++;
                if (ready_at > 0 && vcount == ready_at) begin
                    bus_ready = 1;
                    bus_rdata = rdata;
                end
            end
        end
        dmem_req  = 0;
        bus_ready = 0;
    endtask

    int  vcount;
    bit  got;

    initial begin
        clear_inputs();
        rst_n = 0;
        #1;
        check_all_zero("reset");

        // fetch with zero-wait slave, then a store stalled for five cycles
        vecs[0]  = mk(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h1000, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF,
                      1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 32'h2000, 32'h1234_5678, 4'b0011, 0, 0,
                      0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
        for (int i = 4; i <= 8; i++) begin
            vecs[i] = mk(0, 0, 1, 1, 32'h2000, 32'h1234_5678, 4'b0011, 0, 0,
                         1, 32'h2000, 1, 4'b0011, 32'h1234_5678, 0, 32'hDEAD_BEEF, 0, 0);
        end
        vecs[6].daddr  = 32'h2FFC;
        vecs[6].dwdata = 32'hAAAA_5555;
        vecs[9]  = mk(0, 0, 1, 1, 32'h2000, 32'h1234_5678, 4'b0011, 1, 32'h0000_0055,
                      1, 32'h2000, 1, 4'b0011, 32'h1234_5678, 0, 32'hDEAD_BEEF, 0, 0);
        vecs[10] = mk(0, 0, 1, 1, 32'h2000, 32'h1234_5678, 4'b0011, 0, 0,
                      0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);

        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d bus_valid", i), 32'(bus_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check_output($sformatf("vec%0d bus_addr", i),  bus_addr, vecs[i].e_addr);
                check_output($sformatf("vec%0d bus_we", i),    32'(bus_we), 32'(vecs[i].e_we));
                check_output($sformatf("vec%0d bus_wstrb", i), 32'(bus_wstrb), 32'(vecs[i].e_wstrb));
                check_output($sformatf("vec%0d bus_wdata", i), bus_wdata, vecs[i].e_wdata);
            end
            check_output($sformatf("vec%0d imem_ready", i), 32'(imem_ready), 32'(vecs[i].e_iready));
            check_output($sformatf("vec%0d imem_rdata", i), imem_rdata, vecs[i].e_irdata);
            check_output($sformatf("vec%0d dmem_ready", i), 32'(dmem_ready), 32'(vecs[i].e_dready));
            check_output($sformatf("vec%0d dmem_rdata", i), dmem_rdata, vecs[i].e_drdata);
            check_output($sformatf("vec%0d timeout_irq", i), 32'(timeout_irq), 0);
            @(negedge clk);
        end
        clear_inputs();

        // dead slave: watchdog aborts after exactly eight valid cycles
        run_dmem_load(32'h3000, 0, 0, vcount, got);
        check_output("timeout got ready",   32'(got), 1);
        check_output("timeout valid count", 32'(vcount), 8);
        check_output("timeout dmem_rdata",  dmem_rdata, 32'hFFFF_FFFF);
        check_output("timeout irq",         32'(timeout_irq), 1);
        check_output("timeout addr",        timeout_addr, 32'h3000);
        check_output("timeout imem_ready",  32'(imem_ready), 0);
        @(negedge clk);
        check_output("timeout irq pulse",   32'(timeout_irq), 0);
        check_output("timeout dmem pulse",  32'(dmem_ready), 0);
        check_output("timeout addr sticky", timeout_addr, 32'h3000);

        // ready in the final watchdog cycle completes normally
        run_dmem_load(32'h4000, 8, 32'h600D_CAFE, vcount, got);
        check_output("boundary got ready",   32'(got), 1);
        check_output("boundary valid count", 32'(vcount), 8);
        check_output("boundary dmem_rdata",  dmem_rdata, 32'h600D_CAFE);
        check_output("boundary irq",         32'(timeout_irq), 0);
        check_output("boundary addr sticky", timeout_addr, 32'h3000);
        @(negedge clk);

        // reset while a load is stalled on the bus
        dmem_req = 1; dmem_we = 0; dmem_addr = 32'h5000; bus_ready = 0;
        @(negedge clk);
        @(negedge clk);
        check_output("midreset pre valid", 32'(bus_valid), 1);
        rst_n = 0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1;

        // contention: both masters held high, strict alternation starting with DMEM
        imem_req = 1; imem_addr = 32'h100;
        dmem_req = 1; dmem_we = 0; dmem_addr = 32'h200;
        bus_ready = 1;
        for (int t = 0; t < 18; t++) begin
            bit dm;
            bus_rdata = 32'hC0DE_0000 + 32'(t);
            dm = ((t / 3) % 2) == 0;
            case (t % 3)
                1: begin
                    check_output($sformatf("cont%0d bus_valid", t), 32'(bus_valid), 1);
                    check_output($sformatf("cont%0d bus_addr", t), bus_addr, dm ? 32'h200 : 32'h100);
                    check_output($sformatf("cont%0d ready idle", t), 32'({imem_ready, dmem_ready}), 0);
                end
                2: begin
                    check_output($sformatf("cont%0d bus_valid", t), 32'(bus_valid), 0);
                    check_output($sformatf("cont%0d dmem_ready", t), 32'(dmem_ready), 32'(dm));
                    check_output($sformatf("cont%0d imem_ready", t), 32'(imem_ready), 32'(!dm));
                    check_output($sformatf("cont%0d rdata", t), dm ? dmem_rdata : imem_rdata,
                                 32'hC0DE_0000 + 32'(t - 1));
                end
                default: begin
                    check_output($sformatf("cont%0d bus_valid", t), 32'(bus_valid), 0);
                    check_output($sformatf("cont%0d ready idle", t), 32'({imem_ready, dmem_ready}), 0);
                end
            endcase
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/cix32_mem_arbiter.md
Name: cix32_mem_arbiter

Overview:
- Sits directly downstream of the CIX-32 core's instruction-fetch and data-memory ports.
- Merges the two master request streams onto one shared 32-bit system memory bus.
- Provides round-robin arbitration, request latching, single-outstanding-transaction sequencing and a bus-watchdog timeout.
- On a timeout it reports a fault and returns poisoned data, so the core never hangs on a dead slave.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles bus_valid may stay high without bus_ready before abort; legal range 2..65535.
- TO_W, 16: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_addr  in  32  fetch address.
- imem_req  in  1  fetch request, level; held until imem_ready.
- imem_rdata  out  32  fetch data; valid only while imem_ready=1.
- imem_ready  out  1  one-cycle completion pulse for fetch.
- dmem_addr  in  32  data address.
- dmem_wdata  in  32  store data.
- dmem_wstrb  in  4  store byte enables.
- dmem_we  in  1  1 = store, 0 = load.
- dmem_req  in  1  data request, level; held until dmem_ready.
- dmem_rdata  out  32  load data; valid only while dmem_ready=1.
- dmem_ready  out  1  one-cycle completion pulse for data.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_wstrb  out  4  bus byte enables.
- bus_we  out  1  bus write enable.
- bus_valid  out  1  bus request valid.
- bus_ready  in  1  slave accept/complete.
- bus_rdata  in  32  slave read data; sampled when bus_valid && bus_ready.
- timeout_irq  out  1  one-cycle pulse on watchdog abort.
- timeout_addr  out  32  address of the last aborted transaction (sticky until next abort).

Behaviour:
- Reset values: all outputs 0. State=IDLE, last_grant=IMEM, watchdog count=0.
- Reset asserted mid-transaction forces reset values immediately, including bus_valid=0. The slave must tolerate the abandoned request.
- FSM states: IDLE, BUS, RESP.
- IDLE: samples imem_req/dmem_req each cycle.
  - If exactly one is high, grant it.
  - If both are high, grant the master other than last_grant. The first tie after reset therefore goes to DMEM.
  - On grant: latch addr/wdata/wstrb/we, update last_grant, go to BUS, and drive bus_valid=1 from the next cycle.
  - IMEM grant drives bus_we=0, bus_wstrb=0, bus_wdata=0.
  - DMEM load (dmem_we=0) drives bus_wstrb=0 and bus_wdata=0.
- BUS: bus_addr/wdata/wstrb/we are held stable while bus_valid=1. Master input changes are ignored after latching.
  - If bus_ready=1: the transaction completes. Capture bus_rdata, deassert bus_valid next cycle, go to RESP.
  - Otherwise: increment the watchdog.
  - Abort: if the watchdog equals TIMEOUT_CYCLES-1 and bus_ready=0 in that cycle, go to RESP with rdata=32'hFFFF_FFFF, pulse timeout_irq in the RESP cycle, and load timeout_addr with the latched address.
  - If bus_ready=1 arrives in that same final cycle, normal completion wins: no irq.
- RESP (exactly one cycle):
  - Pulse the granted master's ready and drive its rdata (bus_rdata capture, or FFFF_FFFF on abort).
  - The non-granted ready stays 0 and its rdata holds its previous value.
  - For DMEM stores, dmem_rdata=0.
  - Clear the watchdog and go to IDLE. Requests are not sampled in RESP; the master's req in this cycle belongs to the completing transfer.
- Latency, zero-wait slave: req high in cycle 0 → bus_valid in cycle 1 → ready pulse in cycle 2. Back-to-back issue interval is 3 cycles.
- Exactly one outstanding bus transaction. A master dropping req while in IDLE without a grant is simply not served.
- Contention fairness: with both requests continuously asserted, grants strictly alternate DMEM, IMEM, DMEM, ... Neither master waits more than one transaction.

Test Plan:
- Single fetch: imem_req=1, addr 0x0000_1000, slave ready in the first valid cycle, rdata 0xDEAD_BEEF.
  - bus_valid in cycle 1 with bus_we=0, bus_wstrb=0.
  - imem_ready pulse in cycle 2 with imem_rdata=0xDEAD_BEEF.
  - dmem_ready stays 0.
- Store with wait states: dmem_req=1, we=1, addr 0x2000, wdata 0x1234_5678, wstrb 4'b0011, bus_ready delayed 5 cycles.
  - Bus fields are held stable for all 5 cycles.
  - Single dmem_ready pulse follows; no timeout_irq.
- Contention: both reqs held high for 6 transactions.
  - Grant order is DMEM, IMEM, DMEM, IMEM, DMEM, IMEM.
  - Each ready pulse is one cycle.
- Timeout: TIMEOUT_CYCLES=8, bus_ready tied 0, dmem load at 0x3000.
  - bus_valid high for exactly 8 cycles.
  - Then dmem_ready=1 with dmem_rdata=0xFFFF_FFFF, timeout_irq=1 for one cycle, timeout_addr=0x3000.
- Timeout boundary: bus_ready asserted exactly in the 8th valid cycle → normal completion, no timeout_irq.
- Reset mid-transaction: rst_n low while in BUS.
  - bus_valid and all outputs drop to 0 asynchronously.
  - After release, the first tie is granted to DMEM.
